// File: rtl/scan_pkg.sv
// Shared types and elaboration helpers for the multiplexed display scanner.
package scan_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

  // Widest display the all-off constant generator can describe.
  localparam int MAX_DIGITS = 64;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Anodes are active-low, so "all off" is a run of ones n_digits wide.
  function automatic logic [MAX_DIGITS-1:0] anode_off(input int n_digits);
    logic [MAX_DIGITS-1:0] result;
    result = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n_digits) result[i] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_next_index.sv
// Cyclic search for the next set mask bit after cur; flags when the result
// does not move to a higher index (scan wrapped, or a lone digit repeats).
module rr_next_index
  import scan_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int SEL_W    = max2(1, clog2(N_DIGITS))
) (
  input  logic [N_DIGITS-1:0] mask,
  input  logic [SEL_W-1:0]    cur,
  output logic [SEL_W-1:0]    next_idx,
  output logic                valid,
  output logic                wrap
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    next_idx = cur;
    valid    = 1'b0;
    // Walk from the farthest candidate back to cur+1; the last hit is the nearest.
    for (int k = N_DIGITS; k >= 1; k--) begin
      if (mask[(int'(cur) + k) % N_DIGITS]) begin
        next_idx = SEL_W'((int'(cur) + k) % N_DIGITS);
        valid    = 1'b1;
      end
    end
    wrap = valid && (next_idx <= cur);
  end

endmodule

// File: rtl/scan_display_controller.sv
// Multiplexed common-anode 7-segment scanner: refresh prescaler, blank/on slot FSM,
// PWM brightness, per-digit mask and a frame pulse on every scan wrap.
module scan_display_controller
  import scan_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int DIV         = 1000,
  parameter int BLANK_TICKS = 1,
  parameter int BW          = 4,
  localparam int SEL_W      = max2(1, clog2(N_DIGITS))
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [N_DIGITS-1:0] digit_mask,
  input  logic [BW-1:0]       brightness,
  output logic [N_DIGITS-1:0] anode,
  output logic [SEL_W-1:0]    seg_sel,
  output logic                blank,
  output logic                frame_pulse
);

  localparam int PRE_W = max2(1, clog2(DIV));
  // One counter serves both the blank interval and the PWM phase.
  localparam int PH_W  = max2(max2(1, BW), clog2(BLANK_TICKS));

  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [PH_W-1:0]     ON_LAST    = PH_W'((1 << BW) - 1);
  localparam logic [PH_W-1:0]     BLANK_LAST = PH_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [N_DIGITS-1:0] ANODE_OFF  = N_DIGITS'(anode_off(N_DIGITS));

  logic [PRE_W-1:0]    presc_q;
  logic                tick;
  logic                blank_done;
  logic                slot_end;
  scan_state_t         state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [PH_W-1:0]     bri_q, bri_d;
  logic [SEL_W-1:0]    cur_q, cur_d;
  logic [SEL_W-1:0]    nxt_idx;
  logic                nxt_valid, nxt_wrap;
  logic [N_DIGITS-1:0] anode_d;

  rr_next_index #(
    .N_DIGITS (N_DIGITS),
    .SEL_W    (SEL_W)
  ) u_next (
    .mask     (digit_mask),
    .cur      (cur_q),
    .next_idx (nxt_idx),
    .valid    (nxt_valid),
    .wrap     (nxt_wrap)
  );

  assign tick       = en && (presc_q == PRE_LAST);
  // With no blank interval the FSM leaves S_BLANK on the first enabled clock after reset.
  assign blank_done = (BLANK_TICKS == 0) ? en : (tick && (phase_q == BLANK_LAST));

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    bri_d    = bri_q;
    cur_d    = cur_q;
    slot_end = 1'b0;

    case (state_q)
      S_BLANK: begin
        if (blank_done) begin
          state_d = S_ON;
          phase_d = '0;
          bri_d   = PH_W'(brightness);
        end else if (tick) begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_ON: begin
        if (tick) begin
          if (phase_q == ON_LAST) begin
            slot_end = 1'b1;
            phase_d  = '0;
            if (nxt_valid) cur_d = nxt_idx;
            if (BLANK_TICKS == 0) begin
              bri_d = PH_W'(brightness);
            end else begin
              state_d = S_BLANK;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
    endcase

    // Anode is derived from next-state values so it switches on the same edge as the FSM.
    anode_d = ANODE_OFF;
    if (en && (state_d == S_ON) && (phase_d < bri_d) && digit_mask[cur_d]) begin
      anode_d[cur_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q     <= '0;
      state_q     <= S_BLANK;
      phase_q     <= '0;
      bri_q       <= '0;
      cur_q       <= '0;
      anode       <= ANODE_OFF;
      blank       <= 1'b1;
      frame_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (en) presc_q <= tick ? '0 : presc_q + PRE_W'(1);
      state_q     <= state_d;
      phase_q     <= phase_d;
      bri_q       <= bri_d;
      cur_q       <= cur_d;
      anode       <= anode_d;
      blank       <= (anode_d == ANODE_OFF);
      frame_pulse <= slot_end && nxt_valid && nxt_wrap;
    end
  end

  assign seg_sel = cur_q;

endmodule

// File: tb/tb_scan_display_controller.sv
// Self-checking bench for scan_display_controller (4 digits, DIV=2, 1 blank tick, BW=2).
module tb_scan_display_controller;

  localparam int ND         = 4;
  localparam int DIV        = 2;
  localparam int BT         = 1;
  localparam int BW         = 2;
  localparam int BLANK_CLKS = BT * DIV;
  localparam int SLOT       = (BT + (1 << BW)) * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [ND-1:0] digit_mask = '0;
  logic [BW-1:0] brightness = '0;
  logic [ND-1:0] anode;
  logic [1:0]    seg_sel;
  logic          blank;
  logic          frame_pulse;

  scan_display_controller #(
    .N_DIGITS    (ND),
    .DIV         (DIV),
    .BLANK_TICKS (BT),
    .BW          (BW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .digit_mask  (digit_mask),
    .brightness  (brightness),
    .anode       (anode),
    .seg_sel     (seg_sel),
    .blank       (blank),
    .frame_pulse (frame_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [ND-1:0] mask;
    logic [BW-1:0] bri;
    logic [7:0]    exp;   // {anode, seg_sel, blank, frame_pulse}
  } vec_t;

  logic [7:0] sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position in clocks within the current slot.
  int m_pos, m_cur, m_bri;

  function automatic logic [7:0] dut_word();
    return {anode, seg_sel, blank, frame_pulse};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_cur = 0;
    m_bri = 0;
  endtask

  // Expected outputs after the coming clock edge, given the inputs now applied.
  task automatic model_edge(output logic [7:0] e);
    logic [3:0] an;
    logic       lit, fp;
    int         idx;
    bit         found;
    an  = 4'hF;
    lit = 1'b0;
    fp  = 1'b0;
    if (en) begin
      m_pos++;
      if (m_pos == SLOT) begin
        m_pos = 0;
        found = 1'b0;
        for (int k = 1; k <= ND; k++) begin
          idx = (m_cur + k) % ND;
          if (!found && digit_mask[idx]) begin
            found = 1'b1;
            fp    = (idx <= m_cur);
            m_cur = idx;
          end
        end
      end
      if (m_pos == BLANK_CLKS) m_bri = int'(brightness);
      lit = (m_pos >= BLANK_CLKS) && ((m_pos - BLANK_CLKS) < m_bri * DIV) && digit_mask[m_cur];
    end
    if (lit) an[m_cur] = 1'b0;
    e = {an, 2'(m_cur), (an == 4'hF), fp};
  endtask

  task automatic step();
    logic [7:0] e;
    model_edge(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("scan", 32'(dut_word()), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[12];
    logic [1:0] seq[$];
    logic [1:0] exp_seq[4];
    logic [1:0] prev_sel;
    int         n, lit_cnt, fp_cnt, hold;
    bit         fp_seen;

    // Release at clk 0 with all digits, full brightness: first slot and start of second.
    tbl[0]  = '{1'b1, 4'hF, 2'd3, {4'b1111, 2'd0, 1'b1, 1'b0}};
    tbl[1]  = '{1'b1, 4'hF, 2'd3, {4'b1110, 2'd0, 1'b0, 1'b0}};
    tbl[2]  = '{1'b1, 4'hF, 2'd3, {4'b1110, 2'd0, 1'b0, 1'b0}};
    tbl[3]  = '{1'b1, 4'hF, 2'd3, {4'b1110, 2'd0, 1'b0, 1'b0}};
    tbl[4]  = '{1'b1, 4'hF, 2'd3, {4'b1110, 2'd0, 1'b0, 1'b0}};
    tbl[5]  = '{1'b1, 4'hF, 2'd3, {4'b1110, 2'd0, 1'b0, 1'b0}};
    tbl[6]  = '{1'b1, 4'hF, 2'd3, {4'b1110, 2'd0, 1'b0, 1'b0}};
    tbl[7]  = '{1'b1, 4'hF, 2'd3, {4'b1111, 2'd0, 1'b1, 1'b0}};
    tbl[8]  = '{1'b1, 4'hF, 2'd3, {4'b1111, 2'd0, 1'b1, 1'b0}};
    tbl[9]  = '{1'b1, 4'hF, 2'd3, {4'b1111, 2'd1, 1'b1, 1'b0}};
    tbl[10] = '{1'b1, 4'hF, 2'd3, {4'b1111, 2'd1, 1'b1, 1'b0}};
    tbl[11] = '{1'b1, 4'hF, 2'd3, {4'b1101, 2'd1, 1'b0, 1'b0}};

    // Reset state
    model_reset();
    en = 1'b1; digit_mask = 4'hF; brightness = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dut_word()), 32'({4'hF, 2'd0, 1'b1, 1'b0}));

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; digit_mask = tbl[i].mask; brightness = tbl[i].bri;
      step();
      check($sformatf("tbl%0d", i), 32'(dut_word()), 32'(tbl[i].exp));
    end

    // Sparse mask 1010: scan alternates 1,3 with a frame pulse only on 3->1
    digit_mask = 4'b1010;
    exp_seq = '{2'd3, 2'd1, 2'd3, 2'd1};
    prev_sel = 2'd1;
    fp_cnt = 0;
    for (int i = 0; i < 38; i++) begin
      step();
      if (frame_pulse) begin
        fp_cnt++;
        check("fp_on_wrap_sel", 32'(seg_sel), 32'd1);
      end
      if (seg_sel != prev_sel) seq.push_back(seg_sel);
      prev_sel = seg_sel;
    end
    check("seq_len", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4 && i < seq.size(); i++) check($sformatf("seq%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    check("fp_count", 32'(fp_cnt), 32'd2);

    // Brightness: dark, 1-tick duty, mid-slot change deferred to next slot
    brightness = 2'd0;
    lit_cnt = 0;
    for (int i = 0; i < SLOT; i++) begin step(); if (anode != 4'hF) lit_cnt++; end
    check("bri0_lit_clks", 32'(lit_cnt), 32'd0);
    brightness = 2'd1;
    lit_cnt = 0;
    for (int i = 0; i < SLOT; i++) begin step(); if (anode != 4'hF) lit_cnt++; end
    check("bri1_lit_clks", 32'(lit_cnt), 32'd2);
    lit_cnt = 0;
    for (int i = 0; i < SLOT; i++) begin
      if (i == 4) brightness = 2'd3;
      step();
      if (anode != 4'hF) lit_cnt++;
    end
    check("bri_midslot_lit_clks", 32'(lit_cnt), 32'd2);
    lit_cnt = 0;
    for (int i = 0; i < SLOT; i++) begin step(); if (anode != 4'hF) lit_cnt++; end
    check("bri3_lit_clks", 32'(lit_cnt), 32'd6);

    // All-zero mask: no light, selection held, no frame pulse
    digit_mask = 4'b0000;
    hold = m_cur;
    lit_cnt = 0;
    fp_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (anode != 4'hF) lit_cnt++;
      if (frame_pulse) fp_cnt++;
    end
    check("mask0_lit", 32'(lit_cnt), 32'd0);
    check("mask0_fp", 32'(fp_cnt), 32'd0);
    check("mask0_sel_hold", 32'(seg_sel), 32'(hold));

    digit_mask = 4'b0100;
    n = 0;
    do begin step(); n++; end while (seg_sel != 2'd2 && n < 20);
    check("mask_pickup_clks", 32'(n), 32'(SLOT));
    repeat (2) step();
    check("digit2_lit", 32'(anode), 32'(4'b1011));

    // Enable pause mid-ON: dark at once, slot end delayed by the pause length
    step();
    en = 1'b0;
    step();
    check("en_off_dark", 32'({anode, blank}), 32'({4'hF, 1'b1}));
    n = 1;
    fp_seen = 1'b0;
    while (!fp_seen && n < 40) begin
      n++;
      if (n == 8) en = 1'b1;
      step();
      fp_seen = frame_pulse;
    end
    check("en_pause_slot_end", 32'(n), 32'd14);

    // Asynchronous reset mid-ON, released off the clock edge
    repeat (4) step();
    #3 reset = 1'b0;
    #1;
    check("async_reset_now", 32'(dut_word()), 32'({4'hF, 2'd0, 1'b1, 1'b0}));
    @(posedge clk);
    #1;
    check("async_reset_held", 32'(dut_word()), 32'({4'hF, 2'd0, 1'b1, 1'b0}));
    digit_mask = 4'hF;
    brightness = 2'd3;
    #2 reset = 1'b1;
    model_reset();
    repeat (2) step();
    check("restart_digit0", 32'({anode, seg_sel}), 32'({4'b1110, 2'd0}));
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
